// File: rtl/spi_prog_master.sv
// SPI mode-0 master for the chip's programming port: one 48-bit {addr,data} frame per
// accepted request, MSB first, with the miso bits of the frame returned in rx_data.
module spi_prog_master #(
   parameter int DIV = 4,
   parameter int GAP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] addr,
   input  logic [31:0] data,
   output logic        sclk,
   output logic        mosi,
   output logic        ss,
   input  logic        miso,
   output logic        busy,
   output logic        done,
   output logic [47:0] rx_data
);

   // One counter paces both the sclk half-periods and the inter-frame gap.
   localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
   localparam logic [5:0]       BIT_LAST = 6'd47;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
   logic [5:0]       bit_cnt, bit_cnt_nxt;
   logic [47:0]      tx_sr, tx_sr_nxt;
   logic [47:0]      rx_sr, rx_sr_nxt;
   logic [47:0]      rx_data_nxt;
   logic             sclk_nxt, mosi_nxt, ss_nxt;
   logic             req_ready_nxt, busy_nxt, done_nxt;
   logic             div_wrap;

   assign div_wrap = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt     = state;
      div_cnt_nxt   = div_cnt + CNT_W'(1);
      bit_cnt_nxt   = bit_cnt;
      tx_sr_nxt     = tx_sr;
      rx_sr_nxt     = rx_sr;
      rx_data_nxt   = rx_data;
      sclk_nxt      = sclk;
      mosi_nxt      = mosi;
      ss_nxt        = ss;
      req_ready_nxt = req_ready;
      busy_nxt      = busy;
      done_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            div_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            if (req_valid && req_ready) begin
               tx_sr_nxt     = {addr, data};
               ss_nxt        = 1'b0;
               mosi_nxt      = addr[15];
               busy_nxt      = 1'b1;
               req_ready_nxt = 1'b0;
               state_nxt     = S_SETUP;
            end
         end

         S_SETUP: begin
            if (div_wrap) begin
               div_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               state_nxt   = S_SHIFT;
            end
         end

         // Capture on the rising half, launch the next bit on the falling half.
         S_SHIFT: begin
            if (div_wrap) begin
               div_cnt_nxt = '0;
               sclk_nxt    = ~sclk;
               if (!sclk) begin
                  rx_sr_nxt = {rx_sr[46:0], miso};
               end else if (bit_cnt != BIT_LAST) begin
                  tx_sr_nxt   = {tx_sr[46:0], 1'b0};
                  mosi_nxt    = tx_sr[46];
                  bit_cnt_nxt = bit_cnt + 6'd1;
               end else begin
                  mosi_nxt    = 1'b0;
                  bit_cnt_nxt = '0;
                  state_nxt   = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (div_wrap) begin
               div_cnt_nxt = '0;
               ss_nxt      = 1'b1;
               rx_data_nxt = rx_sr;
               done_nxt    = 1'b1;
               state_nxt   = S_GAP;
            end
         end

         S_GAP: begin
            if (div_cnt == GAP_LAST) begin
               div_cnt_nxt   = '0;
               req_ready_nxt = 1'b1;
               busy_nxt      = 1'b0;
               state_nxt     = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         ss        <= 1'b1;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         rx_data   <= '0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         sclk      <= sclk_nxt;
         mosi      <= mosi_nxt;
         ss        <= ss_nxt;
         req_ready <= req_ready_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         rx_data   <= rx_data_nxt;
      end
   end

   // Shift registers are always fully reloaded/refilled before use, so they need no reset.
   always_ff @(posedge clk) begin
      tx_sr <= tx_sr_nxt;
      rx_sr <= rx_sr_nxt;
   end

endmodule

// File: tb/tb_spi_prog_master.sv
// Bench for spi_prog_master: frame-timeline model checked every cycle on a DIV=2 instance,
// plus directed literal checks on both that instance and a DIV=1/GAP=1 instance.
module tb_spi_prog_master;

   localparam int DIV_A = 2;
   localparam int GAP_A = 4;
   localparam int DIV_B = 1;
   localparam int GAP_B = 1;
   localparam int LOW_A = 98 * DIV_A;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        a_req_valid = 1'b0, a_miso = 1'b0;
   logic [15:0] a_addr = '0;
   logic [31:0] a_data = '0;
   logic        a_req_ready, a_sclk, a_mosi, a_ss, a_busy, a_done;
   logic [47:0] a_rx_data;

   logic        b_req_valid = 1'b0, b_miso = 1'b0;
   logic [15:0] b_addr = '0;
   logic [31:0] b_data = '0;
   logic        b_req_ready, b_sclk, b_mosi, b_ss, b_busy, b_done;
   logic [47:0] b_rx_data;

   spi_prog_master #(.DIV(DIV_A), .GAP(GAP_A)) dut_a (
      .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .addr(a_addr), .data(a_data), .sclk(a_sclk), .mosi(a_mosi), .ss(a_ss),
      .miso(a_miso), .busy(a_busy), .done(a_done), .rx_data(a_rx_data)
   );

   spi_prog_master #(.DIV(DIV_B), .GAP(GAP_B)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .addr(b_addr), .data(b_data), .sclk(b_sclk), .mosi(b_mosi), .ss(b_ss),
      .miso(b_miso), .busy(b_busy), .done(b_done), .rx_data(b_rx_data)
   );

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // ---------------- model of instance A: position in the frame timeline ----------------
   logic [47:0] a_pat   = 48'hA5A50F0F1234;
   bit          m_active = 1'b0;
   int          m_t      = 0;
   logic [47:0] m_frame  = '0;
   logic [47:0] m_rx     = '0;

   // Frame bit on the data lines during cycle t of a frame (t=1 is the cycle after accept).
   function automatic int bit_idx(input int t);
      if (t >= 1 && t <= DIV_A) return 47;
      if (t > DIV_A && t <= 97 * DIV_A) return 47 - ((t - 1 - DIV_A) / DIV_A) / 2;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_active = 1'b0;
         m_t      = 0;
         m_rx     = '0;
      end else if (!m_active) begin
         if (a_req_valid) begin
            m_active = 1'b1;
            m_t      = 1;
            m_frame  = {a_addr, a_data};
         end
      end else begin
         m_t++;
         if (m_t == LOW_A + 1) m_rx = a_pat;
         if (m_t > LOW_A + GAP_A) m_active = 1'b0;
      end
   end

   // Chip-side miso for A: the pattern, advancing on each sclk fall.
   always @(negedge clk) begin : miso_drv
      int bi;
      bi = m_active ? bit_idx(m_t) : -1;
      a_miso = (bi >= 0) ? a_pat[bi] : 1'b0;
   end

   always @(negedge clk) begin : cmp_a
      logic e_ss, e_sclk, e_mosi, e_done;
      int   bi;
      if (chk_en) begin
         e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_done = 1'b0;
         if (m_active) begin
            if (m_t <= LOW_A) e_ss = 1'b0;
            bi = bit_idx(m_t);
            if (bi >= 0) e_mosi = m_frame[bi];
            if (m_t > DIV_A && m_t <= 97 * DIV_A)
               e_sclk = (((m_t - 1 - DIV_A) / DIV_A) % 2) == 1;
            e_done = (m_t == LOW_A + 1);
         end
         chk("a_ss", a_ss, e_ss);
         chk("a_sclk", a_sclk, e_sclk);
         chk("a_mosi", a_mosi, e_mosi);
         chk("a_done", a_done, e_done);
         chk("a_busy", a_busy, m_active);
         chk("a_req_ready", a_req_ready, !m_active);
         chk("a_rx_data", a_rx_data, m_rx);
      end
   end

   // ---------------- frame statistics observed on the wires ----------------
   logic        a_ss_q = 1'b1, a_sclk_q = 1'b0;
   int          a_rises = 0, a_low = 0, a_gap = 0, a_min_gap = 1000, a_dones = 0, a_frames = 0;
   logic [47:0] a_cap = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (a_ss_q && !a_ss) begin
            a_frames++;
            if (a_gap < a_min_gap) a_min_gap = a_gap;
            a_gap = 0; a_rises = 0; a_low = 0; a_cap = '0;
         end
         if (!a_ss) a_low++;
         else a_gap++;
         if (!a_sclk_q && a_sclk) begin
            a_rises++;
            a_cap = {a_cap[46:0], a_mosi};
         end
         if (a_done) a_dones++;
         a_ss_q = a_ss; a_sclk_q = a_sclk;
      end
   end

   logic        b_ss_q = 1'b1, b_sclk_q = 1'b0;
   int          b_rises = 0, b_low = 0, b_dones = 0;
   logic [47:0] b_cap = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (b_ss_q && !b_ss) begin
            b_rises = 0; b_low = 0; b_cap = '0;
         end
         if (!b_ss) b_low++;
         if (!b_sclk_q && b_sclk) begin
            b_rises++;
            b_cap = {b_cap[46:0], b_mosi};
         end
         if (b_done) b_dones++;
         b_ss_q = b_ss; b_sclk_q = b_sclk;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [15:0] q_addr [3] = '{16'h0100, 16'h0101, 16'h0102};
   logic [31:0] q_data [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
   int base;

   initial begin
      reset = 1'b1;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) step();
      chk("rst_ss", a_ss, 1'b1);
      chk("rst_sclk", a_sclk, 1'b0);
      chk("rst_req_ready", a_req_ready, 1'b1);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_rx_data", a_rx_data, 48'h0);
      reset = 1'b0;

      // Single frame, with a foreign request presented mid-frame.
      a_addr = 16'h0004; a_data = 32'hDEADBEEF; a_req_valid = 1'b1;
      step();
      a_req_valid = 1'b0; a_addr = 16'h1234; a_data = 32'h0;
      repeat (30) step();
      a_req_valid = 1'b1; a_addr = 16'hFFFF; a_data = 32'hFFFFFFFF;
      repeat (10) step();
      a_req_valid = 1'b0;
      for (int i = 0; i < 2000 && a_dones < 1; i++) step();
      chk("f1_done_seen", a_dones, 1);
      chk("f1_mosi_bits", a_cap, 48'h0004DEADBEEF);
      chk("f1_rises", a_rises, 48);
      chk("f1_ss_low", a_low, 196);
      chk("f1_rx_data", a_rx_data, 48'hA5A50F0F1234);
      chk("f1_frames", a_frames, 1);

      // Three words presented back to back with req_valid held high.
      a_min_gap = 1000;
      base = a_dones;
      for (int k = 0; k < 3; k++) begin
         a_addr = q_addr[k]; a_data = q_data[k]; a_req_valid = 1'b1;
         for (int i = 0; i < 1000 && !a_req_ready; i++) step();
         step();
      end
      a_req_valid = 1'b0;
      for (int i = 0; i < 3000 && a_dones < base + 3; i++) step();
      chk("q3_dones", a_dones - base, 3);
      chk("q3_frames", a_frames, 4);
      chk("q3_min_gap", a_min_gap, 5);
      chk("q3_last_bits", a_cap, 48'h010233333333);
      chk("q3_rx_data", a_rx_data, 48'hA5A50F0F1234);

      // Reset after the 20th rising sclk edge of a frame.
      for (int i = 0; i < 1000 && !a_req_ready; i++) step();
      a_addr = 16'h8001; a_data = 32'h55AA55AA; a_req_valid = 1'b1;
      step();
      a_req_valid = 1'b0;
      for (int i = 0; i < 1000 && a_rises < 20; i++) step();
      chk("mid_rises_reached", a_rises, 20);
      base = a_dones;
      reset = 1'b1;
      step();
      chk("mid_rst_ss", a_ss, 1'b1);
      chk("mid_rst_sclk", a_sclk, 1'b0);
      chk("mid_rst_busy", a_busy, 1'b0);
      chk("mid_rst_req_ready", a_req_ready, 1'b1);
      chk("mid_rst_rx_data", a_rx_data, 48'h0);
      reset = 1'b0;
      repeat (250) step();
      chk("mid_rst_no_done", a_dones - base, 0);
      chk("mid_rst_rx_kept", a_rx_data, 48'h0);

      // DIV=1, GAP=1 instance.
      b_addr = 16'hFFFF; b_data = 32'h00000001; b_req_valid = 1'b1;
      step();
      b_req_valid = 1'b0;
      chk("b_busy_after_accept", b_busy, 1'b1);
      chk("b_ready_after_accept", b_req_ready, 1'b0);
      for (int i = 0; i < 500 && b_dones < 1; i++) step();
      chk("b_done_seen", b_dones, 1);
      chk("b_busy_at_done", b_busy, 1'b1);
      chk("b_mosi_bits", b_cap, 48'hFFFF00000001);
      chk("b_rises", b_rises, 48);
      chk("b_ss_low", b_low, 98);
      step();
      chk("b_busy_after_gap", b_busy, 1'b0);
      chk("b_ready_after_gap", b_req_ready, 1'b1);
      repeat (20) step();
      chk("b_single_done", b_dones, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
